// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker_pkg
//   Shared definitions for the count-sequence checker:
//   - state_t: checker state encoding (HUNT, SYNC, LOCKED, SLIP)
//   - DEF_*: default parameter values for count_seq_checker
//   - next_count(): +1 modulo 2^width helper
package count_seq_checker_pkg;

    localparam int unsigned DEF_WIDTH      = 3;
    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_UNLOCK_CNT = 2;
    localparam int unsigned DEF_ERRW       = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    // Increment modulo 2^width; caller truncates the result to its own width.
    function automatic logic [31:0] next_count(input logic [31:0] value,
                                               input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk    - clock
//     reset  - synchronous active-high reset (count -> 0)
//     inc    - increment request (ignored once all ones)
//     clr    - synchronous clear; wins over a simultaneous inc
//     count  - current count value [W-1:0]
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Receive-side integrity checker for a free-running modulo-2^WIDTH
//   up-counter stream. Locks after LOCK_CNT consecutive +1 steps, flags
//   each out-of-sequence sample while locked, flywheels the expected value
//   through isolated errors and drops lock after UNLOCK_CNT consecutive
//   misses.
//   Optional: define COUNT_SEQ_CHECKER_STATS_EN to add good_count, a
//   saturating count of matching samples while locked.
//   Ports:
//     clk        - clock
//     reset      - synchronous active-high reset
//     in_valid   - in_data carries a sample this cycle
//     in_data    - received count value [WIDTH-1:0]
//     err_clr    - synchronous clear of err_count (and good_count)
//     locked     - registered; high in LOCKED or SLIP
//     err        - registered one-cycle pulse per counted mismatch
//     err_count  - saturating mismatch count while locked [ERRW-1:0]
//     expected   - next expected value, prev+1 mod 2^WIDTH
//     good_count - (optional) saturating match count while locked
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int unsigned ERRW       = DEF_ERRW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] expected
`ifdef COUNT_SEQ_CHECKER_STATS_EN
    ,
    output logic [ERRW-1:0]  good_count
`endif
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt, exp_val;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [UW-1:0]    miss_cnt, miss_nxt;
    logic             err_nxt;
    logic             hit;

    assign exp_val  = WIDTH'(next_count(32'(prev), WIDTH));
    assign hit      = (in_data == exp_val);
    assign expected = exp_val;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        err_nxt   = 1'b0;
        case (state)
            HUNT: begin
                if (in_valid) begin
                    prev_nxt  = in_data;
                    match_nxt = '0;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (in_valid) begin
                    // Every sample reseeds prev, matching or not.
                    prev_nxt = in_data;
                    if (hit) begin
                        if (32'(match_cnt) + 32'd1 == LOCK_CNT) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + MW'(1);
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    if (hit) begin
                        prev_nxt = in_data;
                    end else begin
                        // Flywheel: advance past the bad sample without using it.
                        err_nxt  = 1'b1;
                        prev_nxt = exp_val;
                        if (UNLOCK_CNT == 1) begin
                            state_nxt = HUNT;
                            miss_nxt  = '0;
                        end else begin
                            state_nxt = SLIP;
                            miss_nxt  = UW'(1);
                        end
                    end
                end
            end
            SLIP: begin
                if (in_valid) begin
                    if (hit) begin
                        prev_nxt  = in_data;
                        miss_nxt  = '0;
                        state_nxt = LOCKED;
                    end else begin
                        err_nxt  = 1'b1;
                        prev_nxt = exp_val;
                        if (32'(miss_cnt) + 32'd1 == UNLOCK_CNT) begin
                            state_nxt = HUNT;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss_cnt + UW'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                match_nxt = '0;
                miss_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            prev      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            locked    <= (state_nxt == LOCKED) || (state_nxt == SLIP);
            err       <= err_nxt;
        end
    end

    sat_counter #(
        .W (ERRW)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_nxt),
        .clr   (err_clr),
        .count (err_count)
    );

`ifdef COUNT_SEQ_CHECKER_STATS_EN
    logic good_inc;
    assign good_inc = in_valid && hit && ((state == LOCKED) || (state == SLIP));

    sat_counter #(
        .W (ERRW)
    ) u_good_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (good_inc),
        .clr   (err_clr),
        .count (good_count)
    );
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
//   Self-checking bench for count_seq_checker. Two instances share one
//   stimulus stream: dut_a uses default parameters, dut_b uses ERRW=2 and
//   UNLOCK_CNT=8. Both are compared every cycle against a behavioural model.
module tb_count_seq_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, err_clr;
    logic [2:0] in_data;

    logic       locked_a, err_a;
    logic [7:0] cnt_a;
    logic [2:0] exp_a;
    logic       locked_b, err_b;
    logic [1:0] cnt_b;
    logic [2:0] exp_b;
`ifdef COUNT_SEQ_CHECKER_STATS_EN
    logic [7:0] good_a;
    logic [1:0] good_b;
`endif

    count_seq_checker #(
        .WIDTH      (3),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2),
        .ERRW       (8)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .err_clr    (err_clr),
        .locked     (locked_a),
        .err        (err_a),
        .err_count  (cnt_a),
        .expected   (exp_a)
`ifdef COUNT_SEQ_CHECKER_STATS_EN
        ,
        .good_count (good_a)
`endif
    );

    count_seq_checker #(
        .WIDTH      (3),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (8),
        .ERRW       (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .err_clr    (err_clr),
        .locked     (locked_b),
        .err        (err_b),
        .err_count  (cnt_b),
        .expected   (exp_b)
`ifdef COUNT_SEQ_CHECKER_STATS_EN
        ,
        .good_count (good_b)
`endif
    );

    int errors = 0;
    int checks = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    // Model: "locked" covers LOCKED and SLIP; misses>0 means slipping.
    typedef struct {
        bit locked;
        bit seeded;
        int run;
        int misses;
        int prev;
        int errs;
        int good;
        bit err;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mstep(mstate_t s, bit rst, bit v, int d, bit clr,
                                      int lockc, int unlockc, int cmax);
        mstate_t n = s;
        int want;
        bit hit;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        n.err = 0;
        if (v) begin
            want = (s.prev + 1) % 8;
            hit  = (d == want);
            if (!s.locked) begin
                if (s.seeded && hit) begin
                    n.run = s.run + 1;
                    if (n.run == lockc) begin
                        n.locked = 1;
                        n.run    = 0;
                    end
                end else begin
                    n.run = 0;
                end
                n.seeded = 1;
                n.prev   = d;
            end else if (hit) begin
                n.prev   = d;
                n.misses = 0;
                if (s.good < cmax) n.good = s.good + 1;
            end else begin
                n.err    = 1;
                if (s.errs < cmax) n.errs = s.errs + 1;
                n.prev   = want;
                n.misses = s.misses + 1;
                if (n.misses == unlockc) begin
                    n.locked = 0;
                    n.seeded = 0;
                    n.misses = 0;
                end
            end
        end
        if (clr) begin
            n.errs = 0;
            n.good = 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input int d, input bit clr);
        reset    = rst;
        in_valid = v;
        in_data  = 3'(d);
        err_clr  = clr;
        @(posedge clk);
        ma = mstep(ma, rst, v, d & 7, clr, 4, 2, 255);
        mb = mstep(mb, rst, v, d & 7, clr, 4, 8, 3);
        #1;
        check("a.locked",    int'(locked_a), int'(ma.locked));
        check("a.err",       int'(err_a),    int'(ma.err));
        check("a.err_count", int'(cnt_a),    ma.errs);
        check("a.expected",  int'(exp_a),    (ma.prev + 1) % 8);
        check("b.locked",    int'(locked_b), int'(mb.locked));
        check("b.err",       int'(err_b),    int'(mb.err));
        check("b.err_count", int'(cnt_b),    mb.errs);
        check("b.expected",  int'(exp_b),    (mb.prev + 1) % 8);
`ifdef COUNT_SEQ_CHECKER_STATS_EN
        check("a.good_count", int'(good_a), ma.good);
        check("b.good_count", int'(good_b), mb.good);
`endif
        if (err_a) pulses_a++;
        if (err_b) pulses_b++;
    endtask

    initial begin
        int cur;
        bit v, bad, clr, rst;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset.locked",    int'(locked_a), 0);
        check("reset.err_count", int'(cnt_a),    0);
        check("reset.expected",  int'(exp_a),    1);

        // 1: clean stream 0..7,0..; lock on the edge after the 5th sample
        for (int i = 0; i < 12; i++) begin
            step(0, 1, i % 8, 0);
            if (i == 3) check("t1.not_locked_4th", int'(locked_a), 0);
            if (i == 4) check("t1.locked_5th",     int'(locked_a), 1);
        end
        check("t1.no_err_through_wrap", pulses_a, 0);
        for (int i = 4; i < 11; i++) step(0, 1, i % 8, 0);   // ends on value 2

        // 2: isolated error 2,5,4 -> one pulse, lock held
        step(0, 1, 5, 0);
        check("t2.err_pulse", int'(err_a),    1);
        check("t2.locked",    int'(locked_a), 1);
        check("t2.err_count", int'(cnt_a),    1);
        step(0, 1, 4, 0);
        check("t2.recovered", int'(locked_a), 1);
        for (int i = 5; i < 11; i++) step(0, 1, i % 8, 0);   // ends on value 2

        // 3: two consecutive misses drop lock, relock after 1+4 samples
        step(0, 1, 6, 0);
        step(0, 1, 6, 0);
        check("t3.unlocked",  int'(locked_a), 0);
        check("t3.err_count", int'(cnt_a),    3);
        step(0, 1, 5, 0);
        step(0, 1, 6, 0);
        step(0, 1, 7, 0);
        step(0, 1, 0, 0);
        check("t3.not_yet", int'(locked_a), 0);
        step(0, 1, 1, 0);
        check("t3.relocked", int'(locked_a), 1);
        cur = 2;

        // 4: random valid gaps with garbage data
        pulses_a = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(0, 1, cur, 0);
                cur = (cur + 1) % 8;
            end else begin
                step(0, 0, int'($urandom_range(0, 7)), 0);
            end
        end
        check("t4.locked",  int'(locked_a), 1);
        check("t4.no_errs", pulses_a, 0);

        // 5: reset mid-lock, then err_clr colliding with a mismatch
        step(1, 1, cur, 0);
        check("t5.reset_locked",   int'(locked_a), 0);
        check("t5.reset_count",    int'(cnt_a),    0);
        check("t5.reset_expected", int'(exp_a),    1);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, cur, 0);
            cur = (cur + 1) % 8;
        end
        step(0, 1, (cur + 3) % 8, 1);
        cur = (cur + 1) % 8;
        check("t5.clr_err_pulse", int'(err_a), 1);
        check("t5.clr_wins",      int'(cnt_a), 0);
        step(0, 1, cur, 0);
        cur = (cur + 1) % 8;

        // 6: five isolated errors saturate the 2-bit counter at 3
        pulses_b = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, (cur + 4) % 8, 0);
            cur = (cur + 1) % 8;
            step(0, 1, cur, 0);
            cur = (cur + 1) % 8;
        end
        check("t6.saturated", int'(cnt_b),    3);
        check("t6.pulses",    pulses_b,       5);
        check("t6.locked",    int'(locked_b), 1);

        // 7: mixed random traffic
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 199) == 0);
            if (v) begin
                step(rst, 1, bad ? int'($urandom_range(0, 7)) : cur, clr);
                cur = (cur + 1) % 8;
            end else begin
                step(rst, 0, int'($urandom_range(0, 7)), clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
